// File: rtl/el_dr_sync_sink.sv
// el_dr_sync_sink: clocked sink for a level-encoded dual-rail (LEDR) token bus.
// It synchronizes both rails of every bit and waits until every bit carries the
// expected phase. It then requires the whole word to hold steady for STABLE_CYC
// more cycles before capturing it. The token is delivered on a valid/ready
// stream, and a 2-phase ack is returned to the ring.
// Build option: EL_SINK_SKID_EN adds a 2-entry FIFO, so the ring is acked at
// capture instead of at consumer hand-off.
// Stream handshake: valid_o/data_o hold steady until a posedge with
// valid_o && ready_i. That edge is the single transfer point. ready_i has no
// effect while valid_o is low.
module el_dr_sync_sink #(
  parameter int WIDTH       = 32,
  parameter int RAIL_NUM    = 2,
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CYC  = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [RAIL_NUM*WIDTH-1:0] in,
  output logic                      ack_o,
  output logic [WIDTH-1:0]          data_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [15:0]               tok_cnt_o
);

  localparam int BW = RAIL_NUM * WIDTH;
  localparam int CW = (STABLE_CYC < 1) ? 1 : $clog2(STABLE_CYC + 1);

  generate
    if (RAIL_NUM != 2) begin : g_bad_rail_num
      $error("el_dr_sync_sink: RAIL_NUM must be 2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
      $error("el_dr_sync_sink: SYNC_STAGES must be at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {S_WAIT, S_STAB, S_CAP, S_HOLD} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_rst_sync;
  logic             w_rst_n;
  logic [BW-1:0]    r_sync [SYNC_STAGES];
  logic [BW-1:0]    w_s;
  logic [BW-1:0]    r_snap;
  logic [WIDTH-1:0] w_ph;
  logic [WIDTH-1:0] w_snap_val;
  logic             w_complete;
  logic             r_exp_ph;
  logic [CW-1:0]    r_stab_cnt;
  logic             r_ack;
  logic [15:0]      r_tok;
  logic             w_push;
  logic             w_pop;
`ifdef EL_SINK_SKID_EN
  logic [WIDTH-1:0] r_mem [2];
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_cnt;
`else
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
`endif

  // Reset asserts asynchronously and deasserts on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  // Per-rail synchronizer chain. The ring is asynchronous to clk.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
    end else begin
      r_sync[0] <= in;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
    end
  end
  assign w_s = r_sync[SYNC_STAGES-1];

  // Phase of each bit is value XOR timing rail. The word is complete only when
  // every bit shows the phase expected for the next token.
  always_comb begin
    w_ph       = '0;
    w_snap_val = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_ph[i]       = w_s[2*i] ^ w_s[2*i+1];
      w_snap_val[i] = r_snap[2*i+1];
    end
    w_complete = (w_ph == {WIDTH{r_exp_ph}});
  end

`ifdef EL_SINK_SKID_EN
  assign w_pop  = (r_cnt != 2'd0) && ready_i;
  assign w_push = (r_state == S_CAP) && ((r_cnt != 2'd2) || w_pop);
`else
  assign w_pop  = (r_state == S_HOLD) && r_valid && ready_i;
  assign w_push = (r_state == S_CAP);
`endif

  // State register.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= S_WAIT;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic: detect a complete word, confirm it is stable, capture,
  // then hold until the token has somewhere to go.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_WAIT: if (w_complete) w_state_nxt = (STABLE_CYC == 0) ? S_CAP : S_STAB;
      S_STAB: begin
        if ((w_s != r_snap) || !w_complete)                         w_state_nxt = S_WAIT;
        else if ((r_stab_cnt == CW'(1)) || (r_stab_cnt == CW'(0)))  w_state_nxt = S_CAP;
      end
`ifdef EL_SINK_SKID_EN
      S_CAP:  if (w_push) w_state_nxt = ((r_cnt == 2'd0) || w_pop) ? S_WAIT : S_HOLD;
      S_HOLD: if ((r_cnt != 2'd2) || w_pop) w_state_nxt = S_WAIT;
`else
      S_CAP:  w_state_nxt = S_HOLD;
      S_HOLD: if (w_pop) w_state_nxt = S_WAIT;
`endif
      default: w_state_nxt = S_WAIT;
    endcase
  end

  // Datapath: snapshot, stability counter, capture, phase, ack and token count.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_snap     <= '0;
      r_stab_cnt <= '0;
      r_exp_ph   <= 1'b1;
      r_ack      <= 1'b0;
      r_tok      <= '0;
`ifdef EL_SINK_SKID_EN
      r_mem[0]   <= '0;
      r_mem[1]   <= '0;
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_cnt      <= 2'd0;
`else
      r_data     <= '0;
      r_valid    <= 1'b0;
`endif
    end else begin
      if ((r_state == S_WAIT) && w_complete) begin
        r_snap     <= w_s;
        r_stab_cnt <= CW'(STABLE_CYC);
      end else if (r_state == S_STAB) begin
        r_stab_cnt <= r_stab_cnt - CW'(1);
      end
      if (w_push) r_exp_ph <= ~r_exp_ph;
      if (w_pop)  r_tok    <= r_tok + 16'd1;
`ifdef EL_SINK_SKID_EN
      if (w_push) begin
        r_mem[r_wptr] <= w_snap_val;
        r_wptr        <= ~r_wptr;
        r_ack         <= ~r_ack;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
`else
      if (w_push) begin
        r_data  <= w_snap_val;
        r_valid <= 1'b1;
      end
      if (w_pop) begin
        r_valid <= 1'b0;
        r_ack   <= ~r_ack;
      end
`endif
    end
  end

  assign ack_o     = r_ack;
  assign tok_cnt_o = r_tok;
`ifdef EL_SINK_SKID_EN
  assign data_o    = r_mem[r_rptr];
  assign valid_o   = (r_cnt != 2'd0);
`else
  assign data_o    = r_data;
  assign valid_o   = r_valid;
`endif

endmodule

// File: tb/tb_el_dr_sync_sink.sv
// Directed bench for el_dr_sync_sink. The bench acts as the LEDR ring, sending
// each token by flipping exactly one rail per bit. It also acts as the stream
// consumer. Expected values are hand-derived.
module tb_el_dr_sync_sink;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [2*W-1:0] bus;
  logic           ack_o;
  logic [W-1:0]   data_o;
  logic           valid_o;
  logic           ready_i;
  logic [15:0]    tok_cnt_o;

  int             n_cmp = 0;
  int             n_err = 0;
  logic           cur_ph;
  logic           exp_ack;
  logic [15:0]    exp_tok;
  int             lat;
  int             n_v;
  logic [W-1:0]   got_v;
  logic [W-1:0]   held;
  logic [2*W-1:0] nb;
  logic [W-1:0]   fib [5];
  logic [W-1:0]   exp_q [$];

  always #5 clk = ~clk;

  el_dr_sync_sink #(.WIDTH(W), .RAIL_NUM(2), .SYNC_STAGES(2), .STABLE_CYC(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (bus),
    .ack_o     (ack_o),
    .data_o    (data_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .tok_cnt_o (tok_cnt_o)
  );

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // LEDR encoding: value rail = bit, timing rail = bit ^ phase.
  function automatic logic [2*W-1:0] enc(input logic [W-1:0] v, input logic p);
    logic [2*W-1:0] e;
    for (int i = 0; i < W; i++) begin
      e[2*i+1] = v[i];
      e[2*i]   = v[i] ^ p;
    end
    return e;
  endfunction

  task automatic send_token(input logic [W-1:0] v);
    cur_ph = ~cur_ph;
    bus    = enc(v, cur_ph);
  endtask

  task automatic wait_valid(input string tag, output int cyc);
    cyc = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (valid_o === 1'b1) begin
        cyc = c;
        break;
      end
    end
    chk({tag, "_valid"}, {31'd0, valid_o}, 1);
  endtask

`ifdef EL_SINK_SKID_EN
  task automatic wait_ack(input string tag, input logic exp);
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (ack_o === exp) break;
    end
    chk(tag, {31'd0, ack_o}, {31'd0, exp});
  endtask
`endif

  initial begin
    fib[0] = 1; fib[1] = 1; fib[2] = 2; fib[3] = 3; fib[4] = 5;
    rst_n   = 1'b0;
    bus     = '0;
    cur_ph  = 1'b0;
    ready_i = 1'b0;
    exp_ack = 1'b0;
    exp_tok = '0;

    // Reset state and idle bus.
    repeat (3) @(negedge clk);
    chk("rst_ack",   {31'd0, ack_o},   0);
    chk("rst_valid", {31'd0, valid_o}, 0);
    chk("rst_data",  data_o,           0);
    chk("rst_tok",   {16'd0, tok_cnt_o}, 0);
    rst_n = 1'b1;
    n_v = 0;
    repeat (20) begin
      @(negedge clk);
      if (valid_o !== 1'b0) n_v++;
    end
    chk("idle_valid_cycles", n_v, 0);
    chk("idle_ack", {31'd0, ack_o}, 0);

`ifdef EL_SINK_SKID_EN
    // Skid build: two tokens acked into the FIFO, third withheld.
    send_token(32'd7);
    wait_ack("skid_ack1", 1'b1);
    send_token(32'd9);
    wait_ack("skid_ack2", 1'b0);
    send_token(32'd11);
    repeat (30) @(negedge clk);
    chk("skid_ack_withheld", {31'd0, ack_o}, 0);
    chk("skid_valid", {31'd0, valid_o}, 1);
    chk("skid_head", data_o, 7);
    exp_q = {32'd7, 32'd9, 32'd11};
    ready_i = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (valid_o === 1'b1) begin
        if (exp_q.size() > 0) chk("skid_drain_data", data_o, exp_q.pop_front());
        else                  chk("skid_extra_token", data_o, 32'hDEAD_BEEF ^ data_o ^ 32'h1);
      end
    end
    chk("skid_left", exp_q.size(), 0);
    chk("skid_ack3", {31'd0, ack_o}, 1);
    chk("skid_tok", {16'd0, tok_cnt_o}, 3);
`else
    // Fibonacci tokens with the consumer always ready.
    ready_i = 1'b1;
    for (int t = 0; t < 5; t++) begin
      send_token(fib[t]);
      wait_valid("fib", lat);
      if (t == 0) chk("latency", lat, 5);
      chk("fib_data", data_o, fib[t]);
      @(negedge clk);
      exp_ack = ~exp_ack;
      exp_tok = exp_tok + 16'd1;
      chk("fib_taken", {31'd0, valid_o}, 0);
      chk("fib_ack", {31'd0, ack_o}, {31'd0, exp_ack});
    end
    chk("fib_tok", {16'd0, tok_cnt_o}, 5);

    // Skewed arrival: word 0x8, one bit per cycle.
    cur_ph = ~cur_ph;
    nb     = enc(32'h8, cur_ph);
    n_v    = 0;
    got_v  = '0;
    for (int i = 0; i < W; i++) begin
      bus[2*i +: 2] = nb[2*i +: 2];
      @(negedge clk);
      if (valid_o === 1'b1) begin n_v++; got_v = data_o; end
    end
    repeat (20) begin
      @(negedge clk);
      if (valid_o === 1'b1) begin n_v++; got_v = data_o; end
    end
    exp_ack = ~exp_ack;
    exp_tok = exp_tok + 16'd1;
    chk("skew_captures", n_v, 1);
    chk("skew_data", got_v, 8);
    chk("skew_ack", {31'd0, ack_o}, {31'd0, exp_ack});
    chk("skew_tok", {16'd0, tok_cnt_o}, {16'd0, exp_tok});

    // Back-pressure: word held and ack withheld while ready_i is low.
    ready_i = 1'b0;
    send_token(32'hA5A5_0F0F);
    wait_valid("bp", lat);
    held = data_o;
    chk("bp_data", held, 32'hA5A5_0F0F);
    repeat (10) begin
      @(negedge clk);
      chk("bp_hold_data",  data_o, 32'hA5A5_0F0F);
      chk("bp_hold_valid", {31'd0, valid_o}, 1);
      chk("bp_hold_ack",   {31'd0, ack_o}, {31'd0, exp_ack});
    end
    ready_i = 1'b1;
    @(negedge clk);
    exp_ack = ~exp_ack;
    exp_tok = exp_tok + 16'd1;
    ready_i = 1'b0;
    chk("bp_taken", {31'd0, valid_o}, 0);
    chk("bp_ack", {31'd0, ack_o}, {31'd0, exp_ack});
    chk("bp_tok", {16'd0, tok_cnt_o}, {16'd0, exp_tok});

    // Reset in HOLD drops the pending token and clears ack.
    send_token(32'd13);
    wait_valid("hold13", lat);
    chk("hold13_data", data_o, 13);
    chk("hold13_ack", {31'd0, ack_o}, 1);
    rst_n  = 1'b0;
    bus    = '0;
    cur_ph = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, valid_o}, 0);
    chk("mid_rst_ack",   {31'd0, ack_o},   0);
    chk("mid_rst_data",  data_o,           0);
    chk("mid_rst_tok",   {16'd0, tok_cnt_o}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    ready_i = 1'b1;
    send_token(32'd21);
    wait_valid("refeed", lat);
    chk("refeed_data", data_o, 21);
    @(negedge clk);
    chk("refeed_ack", {31'd0, ack_o}, 1);
    chk("refeed_tok", {16'd0, tok_cnt_o}, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
